// File: rtl/metrics_counter_bank.sv
// Bank of independent event/cycle counters with sticky overflow and an atomic snapshot.
// Optional per-channel threshold compare is built when METRICS_THRESHOLD_EN is defined.
module metrics_counter_bank #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int INC_WIDTH     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CHANNELS-1:0]               en,
  input  logic [NUM_CHANNELS-1:0]               clear,
  input  logic [NUM_CHANNELS-1:0]               mode,
  input  logic [NUM_CHANNELS*INC_WIDTH-1:0]     inc,
  input  logic                                  snapshot,
`ifdef METRICS_THRESHOLD_EN
  input  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] thresh,
  output logic [NUM_CHANNELS-1:0]               thresh_hit,
`endif
  output logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] cnt,
  output logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] snap_cnt,
  output logic                                  snap_valid,
  output logic [NUM_CHANNELS-1:0]               overflow,
  output logic                                  ovf_irq
);

  localparam int SUM_WIDTH = COUNTER_WIDTH + 1;

  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] cnt_next;
  logic [NUM_CHANNELS-1:0]               ovf_next;
  logic [SUM_WIDTH-1:0]                  amt [NUM_CHANNELS];
  logic [SUM_WIDTH-1:0]                  sum [NUM_CHANNELS];
`ifdef METRICS_THRESHOLD_EN
  logic [NUM_CHANNELS-1:0]               hit_next;
`endif

  // The extra carry bit of each sum is what detects a wrap.
  always_comb begin
    cnt_next = cnt;
    ovf_next = overflow;
`ifdef METRICS_THRESHOLD_EN
    hit_next = thresh_hit;
`endif
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      amt[i] = '0;
      if (en[i]) begin
        amt[i] = mode[i] ? SUM_WIDTH'(inc[i*INC_WIDTH +: INC_WIDTH]) : SUM_WIDTH'(1);
      end
      sum[i] = {1'b0, cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH]} + amt[i];
      if (clear[i]) begin
        cnt_next[i*COUNTER_WIDTH +: COUNTER_WIDTH] = '0;
        ovf_next[i] = 1'b0;
`ifdef METRICS_THRESHOLD_EN
        hit_next[i] = 1'b0;
`endif
      end else begin
        cnt_next[i*COUNTER_WIDTH +: COUNTER_WIDTH] = sum[i][COUNTER_WIDTH-1:0];
        ovf_next[i] = overflow[i] | sum[i][COUNTER_WIDTH];
`ifdef METRICS_THRESHOLD_EN
        hit_next[i] = thresh_hit[i] |
                      (sum[i][COUNTER_WIDTH-1:0] >= thresh[i*COUNTER_WIDTH +: COUNTER_WIDTH]);
`endif
      end
    end
  end

  // Snapshot samples the pre-edge live counters, so it is coherent with a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      snap_cnt   <= '0;
      snap_valid <= 1'b0;
      overflow   <= '0;
      ovf_irq    <= 1'b0;
`ifdef METRICS_THRESHOLD_EN
      thresh_hit <= '0;
`endif
    end else begin
      cnt        <= cnt_next;
      overflow   <= ovf_next;
      snap_valid <= snapshot;
      if (snapshot) begin
        snap_cnt <= cnt;
      end
`ifdef METRICS_THRESHOLD_EN
      thresh_hit <= hit_next;
      ovf_irq    <= |(overflow | thresh_hit);
`else
      ovf_irq    <= |overflow;
`endif
    end
  end

endmodule

// File: tb/tb_metrics_counter_bank.sv
// Directed testbench for metrics_counter_bank, built with 8-bit counters so wraps are reachable.
// Threshold checks are included when METRICS_THRESHOLD_EN is defined.
module tb_metrics_counter_bank;

  localparam int NC = 4;
  localparam int CW = 8;
  localparam int IW = 4;

  logic              clk;
  logic              rst;
  logic [NC-1:0]     en;
  logic [NC-1:0]     clear;
  logic [NC-1:0]     mode;
  logic [NC*IW-1:0]  inc;
  logic              snapshot;
  logic [NC*CW-1:0]  cnt;
  logic [NC*CW-1:0]  snap_cnt;
  logic              snap_valid;
  logic [NC-1:0]     overflow;
  logic              ovf_irq;
`ifdef METRICS_THRESHOLD_EN
  logic [NC*CW-1:0]  thresh;
  logic [NC-1:0]     thresh_hit;
`endif

  int total = 0;
  int bad   = 0;

  metrics_counter_bank #(
    .NUM_CHANNELS(NC),
    .COUNTER_WIDTH(CW),
    .INC_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .clear(clear),
    .mode(mode),
    .inc(inc),
    .snapshot(snapshot),
`ifdef METRICS_THRESHOLD_EN
    .thresh(thresh),
    .thresh_hit(thresh_hit),
`endif
    .cnt(cnt),
    .snap_cnt(snap_cnt),
    .snap_valid(snap_valid),
    .overflow(overflow),
    .ovf_irq(ovf_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string           name;
    logic            rst;
    logic [NC-1:0]   en;
    logic [NC-1:0]   clear;
    logic [NC-1:0]   mode;
    logic [NC*IW-1:0] inc;
    logic            snapshot;
    logic [NC*CW-1:0] exp_cnt;
    logic [NC-1:0]   exp_ovf;
    logic            exp_irq;
    logic            exp_sv;
    logic [NC*CW-1:0] exp_snap;
  } vec_t;

  vec_t vecs [8];

  // Drive one cycle of inputs, then settle 1 time unit past the edge before any check.
  task automatic applyStimulus(input logic r, input logic [NC-1:0] e, input logic [NC-1:0] c,
                               input logic [NC-1:0] m, input logic [NC*IW-1:0] n,
                               input logic s);
    rst      = r;
    en       = e;
    clear    = c;
    mode     = m;
    inc      = n;
    snapshot = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, '0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = '0; clear = '0; mode = '0; inc = '0; snapshot = 1'b0;
`ifdef METRICS_THRESHOLD_EN
    thresh = {NC{8'hFF}};
`endif

    // Sequential table: each row is one cycle, expectations are the state after its edge.
    vecs[0] = '{"reset",     1'b1, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b0,
                32'h0000_0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000};
    vecs[1] = '{"mixmode",   1'b0, 4'b0011, 4'b0000, 4'b0010, 16'h0050, 1'b0,
                32'h0000_0501, 4'b0000, 1'b0, 1'b0, 32'h0000_0000};
    vecs[2] = '{"zeroinc",   1'b0, 4'b0011, 4'b0000, 4'b0010, 16'h0000, 1'b0,
                32'h0000_0502, 4'b0000, 1'b0, 1'b0, 32'h0000_0000};
    vecs[3] = '{"snapclr",   1'b0, 4'b0001, 4'b0010, 4'b0000, 16'h0000, 1'b1,
                32'h0000_0003, 4'b0000, 1'b0, 1'b1, 32'h0000_0502};
    vecs[4] = '{"idle",      1'b0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b0,
                32'h0000_0003, 4'b0000, 1'b0, 1'b0, 32'h0000_0502};
    vecs[5] = '{"snapinc15", 1'b0, 4'b0100, 4'b0000, 4'b0100, 16'h0F00, 1'b1,
                32'h000F_0003, 4'b0000, 1'b0, 1'b1, 32'h0000_0003};
    vecs[6] = '{"snaphold",  1'b0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b1,
                32'h000F_0003, 4'b0000, 1'b0, 1'b1, 32'h000F_0003};
    vecs[7] = '{"clrprio",   1'b0, 4'b0100, 4'b0100, 4'b0000, 16'h0000, 1'b0,
                32'h0000_0003, 4'b0000, 1'b0, 1'b0, 32'h000F_0003};

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].clear, vecs[i].mode, vecs[i].inc,
                    vecs[i].snapshot);
      checkOutput({vecs[i].name, ".cnt"},  64'(cnt),        64'(vecs[i].exp_cnt));
      checkOutput({vecs[i].name, ".ovf"},  64'(overflow),   64'(vecs[i].exp_ovf));
      checkOutput({vecs[i].name, ".irq"},  64'(ovf_irq),    64'(vecs[i].exp_irq));
      checkOutput({vecs[i].name, ".sv"},   64'(snap_valid), 64'(vecs[i].exp_sv));
      checkOutput({vecs[i].name, ".snap"}, 64'(snap_cnt),   64'(vecs[i].exp_snap));
    end

    // Cycle mode: ten enabled cycles on ch0, then hold.
    doReset();
    repeat (10) applyStimulus(1'b0, 4'b0001, '0, '0, '0, 1'b0);
    checkOutput("cyc10.cnt", 64'(cnt), 64'h0000_000A);
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
    checkOutput("cyc10.hold", 64'(cnt), 64'h0000_000A);

    // Event-mode wrap on ch1: 0xFE + 3 -> 0x01 with sticky overflow, irq one cycle later.
    doReset();
    repeat (254) applyStimulus(1'b0, 4'b0010, '0, '0, '0, 1'b0);
    checkOutput("pre.cnt", 64'(cnt), 64'h0000_FE00);
    applyStimulus(1'b0, 4'b0010, '0, 4'b0010, 16'h0030, 1'b0);
    checkOutput("wrap.cnt", 64'(cnt), 64'h0000_0100);
    checkOutput("wrap.ovf", 64'(overflow), 64'h2);
    checkOutput("wrap.irqlag", 64'(ovf_irq), 64'h0);
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
    checkOutput("wrap.irq", 64'(ovf_irq), 64'h1);
    checkOutput("wrap.sticky", 64'(overflow), 64'h2);
    applyStimulus(1'b0, '0, 4'b0010, '0, '0, 1'b0);
    checkOutput("clrovf.ovf", 64'(overflow), 64'h0);
    checkOutput("clrovf.cnt", 64'(cnt), 64'h0);
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
    checkOutput("clrovf.irq", 64'(ovf_irq), 64'h0);

    // Clear priority on ch2 over a same-cycle increment.
    doReset();
    repeat (5) applyStimulus(1'b0, 4'b0100, '0, '0, '0, 1'b0);
    checkOutput("ch2five", 64'(cnt), 64'h0005_0000);
    applyStimulus(1'b0, 4'b0100, 4'b0100, '0, '0, 1'b0);
    checkOutput("clr.cnt", 64'(cnt), 64'h0);
    checkOutput("clr.ovf", 64'(overflow), 64'h0);
    applyStimulus(1'b0, 4'b0100, '0, '0, '0, 1'b0);
    checkOutput("clr.resume", 64'(cnt), 64'h0001_0000);

    // Snapshot coherence with a same-cycle clear of ch0.
    doReset();
    repeat (100) applyStimulus(1'b0, 4'b0011, '0, '0, '0, 1'b0);
    repeat (100) applyStimulus(1'b0, 4'b0010, '0, '0, '0, 1'b0);
    checkOutput("coh.pre", 64'(cnt), 64'h0000_C864);
    applyStimulus(1'b0, 4'b0011, 4'b0001, '0, '0, 1'b1);
    checkOutput("coh.snap", 64'(snap_cnt), 64'h0000_C864);
    checkOutput("coh.sv", 64'(snap_valid), 64'h1);
    checkOutput("coh.cnt", 64'(cnt), 64'h0000_C900);
    applyStimulus(1'b0, 4'b0011, '0, '0, '0, 1'b0);
    checkOutput("coh.svdrop", 64'(snap_valid), 64'h0);
    checkOutput("coh.snaphold", 64'(snap_cnt), 64'h0000_C864);
    checkOutput("coh.cnt2", 64'(cnt), 64'h0000_CA01);

    // Reset mid-operation with ch3 overflowed (15 x 18 = 270 -> 14).
    doReset();
    repeat (18) applyStimulus(1'b0, 4'b1001, '0, 4'b1000, 16'hF000, 1'b0);
    checkOutput("mid.cnt", 64'(cnt), 64'h0E00_0012);
    checkOutput("mid.ovf", 64'(overflow), 64'h8);
    applyStimulus(1'b1, 4'b1001, '0, 4'b1000, 16'hF000, 1'b1);
    checkOutput("rst.cnt", 64'(cnt), 64'h0);
    checkOutput("rst.ovf", 64'(overflow), 64'h0);
    checkOutput("rst.irq", 64'(ovf_irq), 64'h0);
    checkOutput("rst.sv", 64'(snap_valid), 64'h0);
    checkOutput("rst.snap", 64'(snap_cnt), 64'h0);
    applyStimulus(1'b0, 4'b0001, '0, '0, '0, 1'b0);
    checkOutput("rst.resume", 64'(cnt), 64'h1);
    checkOutput("rst.irqlow", 64'(ovf_irq), 64'h0);

`ifdef METRICS_THRESHOLD_EN
    // Threshold on ch3 at 7: rises with cnt==7, stays past it, dropped by clear.
    thresh = {8'h07, 8'hFF, 8'hFF, 8'hFF};
    doReset();
    repeat (6) applyStimulus(1'b0, 4'b1000, '0, '0, '0, 1'b0);
    checkOutput("th.below", 64'(thresh_hit), 64'h0);
    applyStimulus(1'b0, 4'b1000, '0, '0, '0, 1'b0);
    checkOutput("th.cnt7", 64'(cnt), 64'h0700_0000);
    checkOutput("th.hit", 64'(thresh_hit), 64'h8);
    checkOutput("th.irqlag", 64'(ovf_irq), 64'h0);
    applyStimulus(1'b0, 4'b1000, '0, '0, '0, 1'b0);
    checkOutput("th.past", 64'(thresh_hit), 64'h8);
    checkOutput("th.irq", 64'(ovf_irq), 64'h1);
    applyStimulus(1'b0, 4'b1000, 4'b1000, '0, '0, 1'b0);
    checkOutput("th.clr", 64'(thresh_hit), 64'h0);
    checkOutput("th.clrcnt", 64'(cnt), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
